branch_resolve: RTL

- Sits directly downstream of the ALU comparer in the EX stage and consumes its eql/slt flags.
- Resolves conditional branches and jumps, and checks the outcome against the fetch-stage prediction.
- On a mispredict, issues a PC redirect to fetch over a valid/ready handshake, then holds a flush for a fixed number of cycles to squash wrong-path instructions.

---
 rtl/branch_resolve.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch/jump resolution with mispredict recovery.
//
// Decodes the branch condition from the ALU comparer flags (eql/slt),
// registers the resolution, and on a mispredict issues a redirect to
// fetch over a valid/ready handshake, then holds flush for FLUSH_CYCLES.
//
// Parameters:
//   WIDTH         PC / target address width
//   FLUSH_CYCLES  cycles flush is held after the redirect handshake (0..15)
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid / in_ready           branch accept handshake (ready only in IDLE)
//   br_op, eql, slt, pred_taken   branch op, comparer flags, fetch prediction
//   pc_plus4, br_target           fall-through and taken addresses
//   res_valid/res_taken/mispredict  registered resolution pulse
//   redirect_valid/redirect_pc/redirect_ready  redirect handshake to fetch
//   flush                         squash younger IF/ID instructions
//
// Optional feature (macro BRANCH_STATS_EN): stat_clr input and saturating
// 32-bit counters stat_branches, stat_taken, stat_mispred.
//
// State table:
//   IDLE     | accepting branches, in_ready=1
//   REDIRECT | redirect_valid held until fetch accepts
//   FLUSH    | flush held while the down-counter runs out
module branch_resolve #(
    parameter int WIDTH        = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       br_op,
    input  logic             eql,
    input  logic             slt,
    input  logic             pred_taken,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [WIDTH-1:0] br_target,
    output logic             res_valid,
    output logic             res_taken,
    output logic             mispredict,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    input  logic             redirect_ready,
    output logic             flush
`ifdef BRANCH_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_taken,
    output logic [31:0]      stat_mispred
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       taken_dec;
    logic       accept;
    logic       mis_dec;

    always_comb begin
        taken_dec = 1'b0;
        case (br_op)
            3'd0:    taken_dec = eql;
            3'd1:    taken_dec = !eql;
            3'd2:    taken_dec = slt;
            3'd3:    taken_dec = !slt;
            3'd4:    taken_dec = 1'b1;
            default: taken_dec = 1'b0;
        endcase
    end

    // in_ready is forced low while reset is asserted so every output reads 0.
    assign in_ready       = rst_n && (state_q == IDLE);
    assign redirect_valid = (state_q == REDIRECT);
    assign flush          = (state_q == FLUSH);
    assign accept         = in_valid && in_ready;
    assign mis_dec        = taken_dec != pred_taken;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && mis_dec) state_d = REDIRECT;
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end
                end
            end
            FLUSH: begin
                // The counter value is the number of flush cycles left,
                // including the current one.
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            res_valid   <= 1'b0;
            res_taken   <= 1'b0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            res_valid  <= accept;
            res_taken  <= accept && taken_dec;
            mispredict <= accept && mis_dec;
            if (accept && mis_dec) begin
                redirect_pc <= taken_dec ? br_target : pc_plus4;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    // Counters update on the same edge that raises res_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches <= 32'd0;
            stat_taken    <= 32'd0;
            stat_mispred  <= 32'd0;
        end else if (stat_clr) begin
            stat_branches <= 32'd0;
            stat_taken    <= 32'd0;
            stat_mispred  <= 32'd0;
        end else if (accept) begin
            if (stat_branches != 32'hFFFF_FFFF) stat_branches <= stat_branches + 32'd1;
            if (taken_dec && stat_taken != 32'hFFFF_FFFF) stat_taken <= stat_taken + 32'd1;
            if (mis_dec && stat_mispred != 32'hFFFF_FFFF) stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule
